// File: rtl/kpscan_pkg.sv
// Shared types, constants and key-map helpers for the 4x4 keypad scanner.
package kpscan_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        PRESSED   = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    localparam logic [3:0] KPC_COL0 = 4'b0111;
    localparam logic [3:0] KPC_COL1 = 4'b1011;
    localparam logic [3:0] KPC_COL2 = 4'b1101;
    localparam logic [3:0] KPC_COL3 = 4'b1110;
    localparam logic [3:0] KPR_IDLE = 4'b1111;

    // Rows and columns share the same encoding: MSB low means index 0.
    function automatic logic singleLow(input logic [3:0] pattern);
        logic result;
        result = (pattern == KPC_COL0) || (pattern == KPC_COL1) ||
                 (pattern == KPC_COL2) || (pattern == KPC_COL3);
        return result;
    endfunction

    function automatic logic [1:0] lowIndex(input logic [3:0] pattern);
        logic [1:0] result;
        case (pattern)
            KPC_COL1: result = 2'd1;
            KPC_COL2: result = 2'd2;
            KPC_COL3: result = 2'd3;
            default:  result = 2'd0;
        endcase
        return result;
    endfunction

    function automatic logic [3:0] keyMap(input logic [1:0] col, input logic [1:0] row);
        logic [3:0] result;
        case ({col, row})
            4'b00_00: result = 4'd1;
            4'b00_01: result = 4'd4;
            4'b00_10: result = 4'd7;
            4'b00_11: result = 4'd14;
            4'b01_00: result = 4'd2;
            4'b01_01: result = 4'd5;
            4'b01_10: result = 4'd8;
            4'b01_11: result = 4'd0;
            4'b10_00: result = 4'd3;
            4'b10_01: result = 4'd6;
            4'b10_10: result = 4'd9;
            4'b10_11: result = 4'd15;
            4'b11_00: result = 4'd10;
            4'b11_01: result = 4'd11;
            4'b11_10: result = 4'd12;
            default:  result = 4'd13;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/kpscan_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines; idles high.
module kpscan_sync
    import kpscan_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_async,
    output logic [3:0] o_sync
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= KPR_IDLE;
            r_sync <= KPR_IDLE;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/kpscan.sv
// 4x4 keypad scanner with press/release debounce and one event per press.
// Optional auto-repeat of the held key is enabled by defining KPSCAN_REPEAT_EN.
module kpscan
    import kpscan_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 1000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] kpr,
    output logic [3:0] kpc,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_down
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);

    if (SETTLE_CYCLES < 3 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_badParam
        $error("kpscan: cycle parameters below their minimum values");
    end

    logic [3:0]    w_kprS;
    logic [1:0]    w_colIdx;

    state_t        r_state;
    logic [SW-1:0] r_settleCnt;
    logic [DW-1:0] r_debCnt;
    logic [3:0]    r_kpc;
    logic [3:0]    r_rowPat;
    logic          r_keyValid;
    logic [3:0]    r_keyCode;
    logic          r_keyDown;

    state_t        w_nextState;
    logic [SW-1:0] w_nextSettle;
    logic [DW-1:0] w_nextDeb;
    logic [3:0]    w_nextKpc;
    logic [3:0]    w_nextPat;
    logic          w_nextValid;
    logic [3:0]    w_nextCode;
    logic          w_nextDown;

`ifdef KPSCAN_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    logic [RW-1:0] r_rptCnt;
    logic [RW-1:0] w_nextRpt;
`endif

    kpscan_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (kpr),
        .o_sync  (w_kprS)
    );

    assign w_colIdx = lowIndex(r_kpc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= SCAN;
            r_settleCnt <= '0;
            r_debCnt    <= '0;
            r_kpc       <= KPC_COL0;
            r_rowPat    <= KPR_IDLE;
            r_keyValid  <= 1'b0;
            r_keyCode   <= 4'd0;
            r_keyDown   <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_settleCnt <= w_nextSettle;
            r_debCnt    <= w_nextDeb;
            r_kpc       <= w_nextKpc;
            r_rowPat    <= w_nextPat;
            r_keyValid  <= w_nextValid;
            r_keyCode   <= w_nextCode;
            r_keyDown   <= w_nextDown;
        end
    end

`ifdef KPSCAN_REPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rptCnt <= '0;
        end else begin
            r_rptCnt <= w_nextRpt;
        end
    end
`endif

    // Column rotation is a right shift of the active-low one-hot pattern.
    always_comb begin
        w_nextState  = r_state;
        w_nextSettle = r_settleCnt;
        w_nextDeb    = r_debCnt;
        w_nextKpc    = r_kpc;
        w_nextPat    = r_rowPat;
        w_nextValid  = 1'b0;
        w_nextCode   = r_keyCode;
        w_nextDown   = r_keyDown;

        case (r_state)
            SCAN: begin
                if (r_settleCnt == SW'(SETTLE_CYCLES - 1)) begin
                    if (singleLow(w_kprS)) begin
                        w_nextPat   = w_kprS;
                        w_nextDeb   = '0;
                        w_nextState = DEB_PRESS;
                    end else begin
                        w_nextKpc    = {r_kpc[0], r_kpc[3:1]};
                        w_nextSettle = '0;
                    end
                end else begin
                    w_nextSettle = r_settleCnt + SW'(1);
                end
            end
            DEB_PRESS: begin
                if (w_kprS != r_rowPat) begin
                    w_nextState  = SCAN;
                    w_nextSettle = '0;
                end else if (r_debCnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    w_nextValid = 1'b1;
                    w_nextCode  = keyMap(w_colIdx, lowIndex(r_rowPat));
                    w_nextDown  = 1'b1;
                    w_nextState = PRESSED;
                end else begin
                    w_nextDeb = r_debCnt + DW'(1);
                end
            end
            PRESSED: begin
                if (w_kprS == KPR_IDLE) begin
                    w_nextDeb   = '0;
                    w_nextState = DEB_REL;
                end
            end
            DEB_REL: begin
                if (w_kprS != KPR_IDLE) begin
                    w_nextState = PRESSED;
                end else if (r_debCnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    w_nextDown   = 1'b0;
                    w_nextKpc    = {r_kpc[0], r_kpc[3:1]};
                    w_nextSettle = '0;
                    w_nextState  = SCAN;
                end else begin
                    w_nextDeb = r_debCnt + DW'(1);
                end
            end
            default: begin
                w_nextState = SCAN;
            end
        endcase

`ifdef KPSCAN_REPEAT_EN
        w_nextRpt = r_rptCnt;
        if (r_state == DEB_PRESS && w_nextState == PRESSED) begin
            w_nextRpt = '0;
        end else if (r_state == PRESSED || r_state == DEB_REL) begin
            if (r_rptCnt == RW'(REPEAT_CYCLES - 1)) begin
                w_nextValid = 1'b1;
                w_nextRpt   = '0;
            end else begin
                w_nextRpt = r_rptCnt + RW'(1);
            end
        end
        if (w_nextState == SCAN) begin
            w_nextRpt = '0;
        end
`endif
    end

    assign kpc       = r_kpc;
    assign key_valid = r_keyValid;
    assign key_code  = r_keyCode;
    assign key_down  = r_keyDown;

endmodule

// File: doc/kpscan.md
# kpscan

Keypad matrix scanner for the 4x4 front-panel keypad. Drives the active-low column lines one at a time and samples the active-low row lines. Debounces presses and releases, then emits one registered key event per press, carrying the same 4-bit key code used throughout the channel-strip control path. Sits between the keypad pins and the parameter-control logic.

## Interface
- SETTLE_CYCLES, 1000: cycles each column is driven before rows are sampled; minimum 3.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a press or a release; 10 ms at 50 MHz; minimum 2.
- REPEAT_CYCLES, 25000000: auto-repeat period; used only when KPSCAN_REPEAT_EN is defined.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- kpr  input  4  keypad rows, active-low, asynchronous to clk. Bit 3 is row 0; bit 0 is row 3.
- kpc  output  4  keypad columns, active-low one-hot. Bit 3 is column 0; bit 0 is column 3.
- key_valid  output  1  one-cycle pulse; key_code is valid in the same cycle.
- key_code  output  4  code of the last accepted key; holds its value between events.
- key_down  output  1  high from acceptance of a press until acceptance of its release.

## Operation
- Reset values:
  - kpc=4'b0111, key_valid=0, key_code=0, key_down=0.
  - State SCAN, all counters 0, synchronizer flops 4'b1111.
- kpr passes through a 2-flop synchronizer (kpr_s). All decisions use kpr_s.
- Key map, listed by column, rows 0..3:
  - col0: 1, 4, 7, 14
  - col1: 2, 5, 8, 0
  - col2: 3, 6, 9, 15
  - col3: 10, 11, 12, 13
- SCAN:
  - settle_cnt counts 0..SETTLE_CYCLES-1 for each column.
  - At SETTLE_CYCLES-1, if kpr_s has exactly one row low: capture the row pattern, hold kpc, go to DEB_PRESS.
  - Otherwise (all rows high, or two or more rows low): advance the column 0111->1011->1101->1110->0111 and clear settle_cnt.
- DEB_PRESS:
  - deb_cnt increments each cycle while kpr_s equals the captured pattern.
  - Any mismatch: return to SCAN on the same column with settle_cnt=0. No event is emitted.
  - Match at deb_cnt=DEBOUNCE_CYCLES-1: next cycle key_valid=1, key_code=map(col,row), key_down=1; go to PRESSED.
- PRESSED:
  - kpc is held.
  - kpr_s==4'b1111: go to DEB_REL with deb_cnt=0.
  - Any other pattern, including a different single row: stay in PRESSED. Rollover is ignored.
- DEB_REL:
  - deb_cnt increments while kpr_s==4'b1111.
  - Any low row: back to PRESSED. No event is emitted.
  - At DEBOUNCE_CYCLES-1: next cycle key_down=0, kpc advances to the next column, go to SCAN with settle_cnt=0.
- Reset asserted in any state forces the reset values immediately. No event is emitted for a key that was in progress.

## Timing
- Column dwell in SCAN is exactly SETTLE_CYCLES cycles. A full idle scan takes 4*SETTLE_CYCLES cycles.
- Press latency, from the first kpr edge on the driven column:
  - Synchronizer delay: 2 cycles.
  - Plus the wait until the next settle sample: 0..SETTLE_CYCLES-1 cycles, or up to 4*SETTLE_CYCLES if the key's column is not driven.
  - Plus DEBOUNCE_CYCLES, plus 1 cycle to key_valid.
- Release latency: 2 + DEBOUNCE_CYCLES + 1 cycles to key_down falling.
- key_valid is never high for two consecutive cycles.
- kpc changes only on clk edges and never has more than one bit low.

## Configuration
- KPSCAN_REPEAT_EN defined:
  - In PRESSED and DEB_REL, rpt_cnt counts from the initial key_valid.
  - At REPEAT_CYCLES-1: pulse key_valid with the unchanged key_code, clear rpt_cnt.
  - rpt_cnt clears on entering SCAN.
- KPSCAN_REPEAT_EN undefined: no repeat logic is synthesized. Exactly one key_valid per press.

## Structure
- kpscan_pkg:
  - State enum (SCAN, DEB_PRESS, PRESSED, DEB_REL).
  - Constants: KPC_COL0..KPC_COL3, KPR_IDLE=4'b1111.
  - Key-map function (col index, row index) -> 4-bit code.
- Sub-module kpscan_sync: 4-bit, 2-flop synchronizer with async reset to 1111. No other sub-modules.

## Test plan
Bench parameters: SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32. The bench matrix model pulls a row low only while that key's column is low.
- Reset, no keys -> kpc=0111, key_valid=0, key_code=0, key_down=0; kpc then cycles 0111, 1011, 1101, 1110, 0111, 4 cycles each.
- Hold key 5 (row1, col1) -> one key_valid with key_code=5; key_down=1; kpc frozen at 1011.
- Key 9 bouncing, low for 5 cycles then high 1 cycle, repeated -> no key_valid; scanning continues.
- Release key 5, rows 1111 for 8+ cycles -> key_down falls 11 cycles after the release edge; kpc next 1101.
- Hold key 13 for 100 cycles after acceptance -> with KPSCAN_REPEAT_EN, 3 further key_valid pulses 32 cycles apart, code 13; without it, exactly one pulse.
- Assert reset while in PRESSED with key 0 held -> outputs return to reset values at once; after deassertion, a fresh debounce precedes any key_valid.
